// File: rtl/vcache_dma_arbiter.sv
// vcache_dma_arbiter: shares one DRAM-side DMA channel among num_cache_p vcaches.
// Packets are granted round-robin, a granted write locks the write-data path for
// one full block, and read fills are routed back to the requesting cache in order.
module vcache_dma_arbiter #(
   parameter int num_cache_p           = 2,
   parameter int addr_width_p          = 32,
   parameter int data_width_p          = 32,
   parameter int block_size_in_words_p = 8,
   parameter int read_fifo_els_p       = 4,
   parameter int dma_pkt_width_lp      = addr_width_p + 1
) (
   input  logic                                           clk_i,
   input  logic                                           reset_i,

   input  logic [num_cache_p-1:0][dma_pkt_width_lp-1:0]   dma_pkt_i,
   input  logic [num_cache_p-1:0]                         dma_pkt_v_i,
   output logic [num_cache_p-1:0]                         dma_pkt_yumi_o,

   output logic [num_cache_p-1:0][data_width_p-1:0]       dma_data_o,
   output logic [num_cache_p-1:0]                         dma_data_v_o,
   input  logic [num_cache_p-1:0]                         dma_data_ready_i,

   input  logic [num_cache_p-1:0][data_width_p-1:0]       dma_data_i,
   input  logic [num_cache_p-1:0]                         dma_data_v_i,
   output logic [num_cache_p-1:0]                         dma_data_yumi_o,

   output logic [dma_pkt_width_lp-1:0]                    mem_pkt_o,
   output logic                                           mem_pkt_v_o,
   input  logic                                           mem_pkt_yumi_i,

   input  logic [data_width_p-1:0]                        mem_rdata_i,
   input  logic                                           mem_rdata_v_i,
   output logic                                           mem_rdata_ready_o,

   output logic [data_width_p-1:0]                        mem_wdata_o,
   output logic                                           mem_wdata_v_o,
   input  logic                                           mem_wdata_yumi_i
);

   localparam int id_w   = $clog2(num_cache_p);
   localparam int cnt_w  = $clog2(block_size_in_words_p);
   localparam int fptr_w = $clog2(read_fifo_els_p);
   localparam int fcnt_w = $clog2(read_fifo_els_p + 1);

   typedef enum logic {IDLE, WDATA} state_e;

   state_e              state_q, state_d;
   logic [id_w-1:0]     rr_ptr_q, rr_ptr_d;
   logic [id_w-1:0]     wr_id_q, wr_id_d;
   logic [cnt_w-1:0]    wr_cnt_q, wr_cnt_d;
   logic [cnt_w-1:0]    rd_cnt_q, rd_cnt_d;
   logic [id_w-1:0]     fifo_mem_q [read_fifo_els_p];
   logic [id_w-1:0]     fifo_mem_d [read_fifo_els_p];
   logic [fptr_w-1:0]   fifo_rptr_q, fifo_rptr_d;
   logic [fptr_w-1:0]   fifo_wptr_q, fifo_wptr_d;
   logic [fcnt_w-1:0]   fifo_cnt_q, fifo_cnt_d;

   logic                grant_found;
   logic [id_w-1:0]     grant_id;
   logic [id_w-1:0]     cand;
   logic                fifo_full, fifo_empty;
   logic [id_w-1:0]     head_id;
   logic                pkt_hs, wr_hs, rd_hs, push, pop;

   // Round-robin grant: first valid requester scanning upward from rr_ptr_q with wrap
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      cand        = rr_ptr_q;
      for (int unsigned i = 0; i < num_cache_p; i++) begin
         if (!grant_found && dma_pkt_v_i[cand]) begin
            grant_found = 1'b1;
            grant_id    = cand;
         end
         cand = (cand == id_w'(num_cache_p - 1)) ? '0 : cand + 1'b1;
      end
   end

   // Handshakes, packet/write/read-return outputs
   always_comb begin
      fifo_full   = (fifo_cnt_q == fcnt_w'(read_fifo_els_p));
      fifo_empty  = (fifo_cnt_q == '0);
      head_id     = fifo_mem_q[fifo_rptr_q];

      mem_pkt_o   = dma_pkt_i[grant_id];
      mem_pkt_v_o = (state_q == IDLE) && grant_found && !fifo_full;
      pkt_hs      = mem_pkt_v_o && mem_pkt_yumi_i;

      mem_wdata_o   = dma_data_i[wr_id_q];
      mem_wdata_v_o = (state_q == WDATA) && dma_data_v_i[wr_id_q];
      wr_hs         = mem_wdata_v_o && mem_wdata_yumi_i;

      mem_rdata_ready_o = !fifo_empty && dma_data_ready_i[head_id];
      rd_hs             = mem_rdata_v_i && mem_rdata_ready_o;

      push = pkt_hs && !mem_pkt_o[dma_pkt_width_lp-1];
      pop  = rd_hs && (rd_cnt_q == cnt_w'(block_size_in_words_p - 1));

      dma_pkt_yumi_o = '0;
      if (pkt_hs) dma_pkt_yumi_o[grant_id] = 1'b1;

      dma_data_yumi_o = '0;
      if (wr_hs) dma_data_yumi_o[wr_id_q] = 1'b1;

      dma_data_v_o = '0;
      if (mem_rdata_v_i && !fifo_empty) dma_data_v_o[head_id] = 1'b1;

      for (int unsigned i = 0; i < num_cache_p; i++) dma_data_o[i] = mem_rdata_i;
   end

   // Next-state: request FSM, round-robin pointer, write/read counters, read-id FIFO
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      wr_id_d     = wr_id_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      fifo_mem_d  = fifo_mem_q;
      fifo_rptr_d = fifo_rptr_q;
      fifo_wptr_d = fifo_wptr_q;
      fifo_cnt_d  = fifo_cnt_q;

      case (state_q)
         IDLE: begin
            if (pkt_hs) begin
               rr_ptr_d = (grant_id == id_w'(num_cache_p - 1)) ? '0 : grant_id + 1'b1;
               if (mem_pkt_o[dma_pkt_width_lp-1]) begin
                  wr_id_d  = grant_id;
                  wr_cnt_d = '0;
                  state_d  = WDATA;
               end
            end
         end
         WDATA: begin
            if (wr_hs) begin
               wr_cnt_d = wr_cnt_q + 1'b1;
               if (wr_cnt_q == cnt_w'(block_size_in_words_p - 1)) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (rd_hs) rd_cnt_d = pop ? '0 : rd_cnt_q + 1'b1;

      if (push) begin
         fifo_mem_d[fifo_wptr_q] = grant_id;
         fifo_wptr_d = (fifo_wptr_q == fptr_w'(read_fifo_els_p - 1)) ? '0 : fifo_wptr_q + 1'b1;
      end
      if (pop) begin
         fifo_rptr_d = (fifo_rptr_q == fptr_w'(read_fifo_els_p - 1)) ? '0 : fifo_rptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
         2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         wr_id_q     <= '0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         fifo_rptr_q <= '0;
         fifo_wptr_q <= '0;
         fifo_cnt_q  <= '0;
         for (int unsigned i = 0; i < read_fifo_els_p; i++) fifo_mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         wr_id_q     <= wr_id_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         fifo_rptr_q <= fifo_rptr_d;
         fifo_wptr_q <= fifo_wptr_d;
         fifo_cnt_q  <= fifo_cnt_d;
         fifo_mem_q  <= fifo_mem_d;
      end
   end

   // Read data with no outstanding read is a memory-side protocol error
   always_ff @(posedge clk_i) begin
      if (!reset_i && mem_rdata_v_i && fifo_empty)
         $error("vcache_dma_arbiter: read data returned with no outstanding read");
   end

endmodule
